// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings and owner codes for the memory-port arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision (CPU over DMA) with a starvation streak counter.
// Optional MEM_ARB_LOCK_EN adds cpuLock, which blocks DMA grants while held.
module mem_arb_select
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic cpuReq,
   input  logic dmaReq,
   input  logic grantEn,
`ifdef MEM_ARB_LOCK_EN
   input  logic cpuLock,
`endif
   output logic grantCpu,
   output logic grantDma
);

   localparam logic [3:0] STARVE_W = 4'(STARVE);

   logic [3:0] streak_reg, streak_next;
   logic       locked;
   logic       starved;

   always_comb begin
      locked = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      locked = cpuLock;
`endif
      // A held lock suppresses the starvation override but not the counting.
      starved  = (streak_reg == STARVE_W) && !locked;
      grantCpu = grantEn && cpuReq && !(dmaReq && starved);
      grantDma = grantEn && dmaReq && !locked && (!cpuReq || starved);

      streak_next = streak_reg;
      if (grantDma)
         streak_next = '0;
      else if (grantCpu)
         streak_next = !dmaReq ? '0 :
                       (streak_reg == STARVE_W) ? streak_reg : streak_reg + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         streak_reg <= '0;
      else
         streak_reg <= streak_next;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU > DMA) arbiter for a single memory port with wait states.
// Build option MEM_ARB_LOCK_EN adds the cpuLock input for atomic CPU sequences.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int M      = 16,
   parameter int WAIT   = 1,
   parameter int STARVE = 4
) (
   input  logic         clk,
   input  logic         rst,
`ifdef MEM_ARB_LOCK_EN
   input  logic         cpuLock,
`endif
   input  logic         cpuReq,
   input  logic         cpuWE,
   input  logic [M-1:0] cpuAddr,
   input  logic [M-1:0] cpuWData,
   output logic [M-1:0] cpuRData,
   output logic         cpuAck,
   input  logic         dmaReq,
   input  logic         dmaWE,
   input  logic [M-1:0] dmaAddr,
   input  logic [M-1:0] dmaWData,
   output logic [M-1:0] dmaRData,
   output logic         dmaAck,
   output logic [M-1:0] memAddr,
   output logic [M-1:0] memWrite,
   input  logic [M-1:0] memRead,
   output logic         memWE,
   output logic         busy,
   output logic         owner
);

   arb_state_t state_reg, state_next;

   logic [M-1:0] addr_reg, wdata_reg, cpu_rdata_reg, dma_rdata_reg;
   logic         we_reg, owner_reg;
   logic [3:0]   wait_reg;
   logic         grant_en, grant_cpu, grant_dma, last_access;

   assign grant_en    = (state_reg == ARB_IDLE);
   assign last_access = (state_reg == ARB_ACCESS) && (wait_reg == 4'd0);

   mem_arb_select #(.STARVE(STARVE)) u_select (
      .clk      (clk),
      .rst      (rst),
      .cpuReq   (cpuReq),
      .dmaReq   (dmaReq),
      .grantEn  (grant_en),
`ifdef MEM_ARB_LOCK_EN
      .cpuLock  (cpuLock && (owner_reg == OWNER_CPU)),
`endif
      .grantCpu (grant_cpu),
      .grantDma (grant_dma)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= ARB_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cpuAck     = 1'b0;
      dmaAck     = 1'b0;
      memWE      = 1'b0;
      busy       = (state_reg != ARB_IDLE);
      case (state_reg)
         ARB_IDLE: begin
            if (grant_cpu || grant_dma)
               state_next = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            memWE = we_reg;
            if (wait_reg == 4'd0)
               state_next = ARB_DONE;
         end
         ARB_DONE: begin
            cpuAck     = (owner_reg == OWNER_CPU);
            dmaAck     = (owner_reg == OWNER_DMA);
            state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Request fields are captured once at grant; requesters may change them afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg      <= '0;
         wdata_reg     <= '0;
         we_reg        <= 1'b0;
         owner_reg     <= OWNER_CPU;
         wait_reg      <= '0;
         cpu_rdata_reg <= '0;
         dma_rdata_reg <= '0;
      end else begin
         if (grant_cpu) begin
            addr_reg  <= cpuAddr;
            wdata_reg <= cpuWData;
            we_reg    <= cpuWE;
            owner_reg <= OWNER_CPU;
            wait_reg  <= 4'(WAIT);
         end else if (grant_dma) begin
            addr_reg  <= dmaAddr;
            wdata_reg <= dmaWData;
            we_reg    <= dmaWE;
            owner_reg <= OWNER_DMA;
            wait_reg  <= 4'(WAIT);
         end else if ((state_reg == ARB_ACCESS) && (wait_reg != 4'd0)) begin
            wait_reg <= wait_reg - 4'd1;
         end

         if (last_access && !we_reg) begin
            if (owner_reg == OWNER_CPU)
               cpu_rdata_reg <= memRead;
            else
               dma_rdata_reg <= memRead;
         end
      end
   end

   assign memAddr  = addr_reg;
   assign memWrite = wdata_reg;
   assign cpuRData = cpu_rdata_reg;
   assign dmaRData = dma_rdata_reg;
   assign owner    = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (WAIT=1, STARVE=4): vector table,
// directed multi-cycle sequences, and randomized traffic against a transaction model.
module tb_mem_arbiter;

   localparam int M      = 16;
   localparam int WAIT   = 1;
   localparam int STARVE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cpuReq = 1'b0, cpuWE = 1'b0, dmaReq = 1'b0, dmaWE = 1'b0;
   logic [15:0] cpuAddr = '0, cpuWData = '0, dmaAddr = '0, dmaWData = '0;
   logic [15:0] cpuRData, dmaRData, memAddr, memWrite, memRead;
   logic cpuAck, dmaAck, memWE, busy, owner;
`ifdef MEM_ARB_LOCK_EN
   logic cpuLock = 1'b0;
`endif

   logic        rd_force = 1'b0;
   logic [15:0] rd_val = '0;
   logic [15:0] mem [256];
   logic [15:0] model_mem [16];

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        dma;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rd;
      logic [15:0] exp_cpu_rd;
      logic [15:0] exp_dma_rd;
      logic        exp_owner;
   } vec_t;

   vec_t vecs[6];
   vec_t x;

   // transaction-level reference model state
   int          m_t;        // -1 idle, 1..WAIT+1 access, WAIT+2 done
   int          m_streak;
   logic        m_owner, m_we;
   logic [15:0] m_addr, m_wd;
   logic [15:0] exp_rd [2];
   logic        gd;
   int          n_ack, k;

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(int i);
      return 16'(i * 291 + 23130);
   endfunction

   always @(posedge clk) begin
      if (rst)
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      else if (memWE)
         mem[memAddr[7:0]] <= memWrite;
   end
   assign memRead = rd_force ? rd_val : mem[memAddr[7:0]];

   mem_arbiter #(.M(M), .WAIT(WAIT), .STARVE(STARVE)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MEM_ARB_LOCK_EN
      .cpuLock  (cpuLock),
`endif
      .cpuReq   (cpuReq),
      .cpuWE    (cpuWE),
      .cpuAddr  (cpuAddr),
      .cpuWData (cpuWData),
      .cpuRData (cpuRData),
      .cpuAck   (cpuAck),
      .dmaReq   (dmaReq),
      .dmaWE    (dmaWE),
      .dmaAddr  (dmaAddr),
      .dmaWData (dmaWData),
      .dmaRData (dmaRData),
      .dmaAck   (dmaAck),
      .memAddr  (memAddr),
      .memWrite (memWrite),
      .memRead  (memRead),
      .memWE    (memWE),
      .busy     (busy),
      .owner    (owner)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cpuReq = 1'b0;
      dmaReq = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      // ---------------- reset state ----------------
      step();
      step();
      chk16("rst_memAddr", memAddr, 16'h0);
      chk16("rst_memWrite", memWrite, 16'h0);
      chk16("rst_cpuRData", cpuRData, 16'h0);
      chk16("rst_dmaRData", dmaRData, 16'h0);
      chk1("rst_memWE", memWE, 1'b0);
      chk1("rst_acks", cpuAck | dmaAck, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      rst = 1'b0;

      // ---------------- isolated transfers ----------------
      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hDEAD, 16'hBEEF, 16'h0000, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 16'h0033, 16'h0000, 16'hA5A5, 16'hBEEF, 16'hA5A5, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 16'h0044, 16'h7777, 16'h1111, 16'hBEEF, 16'hA5A5, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'hA5A5, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1};
      rd_force = 1'b1;
      for (int v = 0; v < 6; v++) begin
         x = vecs[v];
         rd_val = x.rd;
         if (x.dma) begin
            dmaReq = 1'b1; dmaWE = x.we; dmaAddr = x.addr; dmaWData = x.wdata;
         end else begin
            cpuReq = 1'b1; cpuWE = x.we; cpuAddr = x.addr; cpuWData = x.wdata;
         end
         for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) begin
               // fields only need to be valid in the granted cycle
               cpuAddr = ~x.addr; cpuWData = ~x.wdata; cpuWE = ~x.we;
               dmaAddr = ~x.addr; dmaWData = ~x.wdata; dmaWE = ~x.we;
            end
            chk1("vec_busy", busy, c <= 3);
            chk1("vec_memWE", memWE, (c <= 2) && x.we);
            chk1("vec_cpuAck", cpuAck, (c == 3) && !x.dma);
            chk1("vec_dmaAck", dmaAck, (c == 3) && x.dma);
            if (c <= 2) begin
               chk16("vec_memAddr", memAddr, x.addr);
               if (x.we) chk16("vec_memWrite", memWrite, x.wdata);
            end
            if (c >= 3) begin
               chk16("vec_cpuRData", cpuRData, x.exp_cpu_rd);
               chk16("vec_dmaRData", dmaRData, x.exp_dma_rd);
               chk1("vec_owner", owner, x.exp_owner);
            end
            if (c == 3) begin
               cpuReq = 1'b0;
               dmaReq = 1'b0;
               $display("[TB] vec %0d %s %s addr=%h wdata=%h cpuRData=%h dmaRData=%h",
                        v, x.dma ? "dma" : "cpu", x.we ? "wr" : "rd", x.addr, x.wdata,
                        cpuRData, dmaRData);
            end
         end
      end
      rd_force = 1'b0;

      // ---------------- simultaneous requests ----------------
      do_reset();
      cpuReq = 1'b1; cpuWE = 1'b0; cpuAddr = 16'h0005;
      dmaReq = 1'b1; dmaWE = 1'b0; dmaAddr = 16'h0009;
      for (int c = 1; c <= 8; c++) begin
         step();
         chk1("both_cpuAck", cpuAck, c == 3);
         chk1("both_dmaAck", dmaAck, c == 7);
         if (c == 3) begin
            chk16("both_cpuRData", cpuRData, init_word(5));
            cpuReq = 1'b0;
            $display("[TB] both: cpu rd addr=0005 data=%h", cpuRData);
         end
         if (c == 7) begin
            chk16("both_dmaRData", dmaRData, init_word(9));
            dmaReq = 1'b0;
            $display("[TB] both: dma rd addr=0009 data=%h", dmaRData);
         end
      end

      // ---------------- starvation guard ----------------
      do_reset();
      cpuReq = 1'b1; cpuWE = 1'b0; cpuAddr = 16'h0001;
      dmaReq = 1'b1; dmaWE = 1'b0; dmaAddr = 16'h0002;
      n_ack = 0;
      for (int c = 0; c < 41; c++) begin
         step();
         if (cpuAck || dmaAck) begin
            chk1("starve_one_ack", cpuAck ^ dmaAck, 1'b1);
            chk1("starve_grant_is_dma", dmaAck, (n_ack % 5) == 4);
            $display("[TB] starve xfer %0d -> %s", n_ack, dmaAck ? "dma" : "cpu");
            n_ack++;
         end
      end
      chk16("starve_xfer_count", 16'(n_ack), 16'd10);
      cpuReq = 1'b0; dmaReq = 1'b0;

      // ---------------- reset during access ----------------
      do_reset();
      cpuReq = 1'b1; cpuWE = 1'b1; cpuAddr = 16'h0020; cpuWData = 16'hCAFE;
      step();
      step();
      chk1("rstmid_in_access", memWE, 1'b1);
      rst = 1'b1;
      step();
      chk1("rstmid_memWE", memWE, 1'b0);
      chk1("rstmid_busy", busy, 1'b0);
      chk1("rstmid_cpuAck", cpuAck, 1'b0);
      rst = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         step();
         chk1("rstmid_re_ack", cpuAck, c == 3);
         chk1("rstmid_re_memWE", memWE, c <= 2);
      end
      $display("[TB] rstmid: cpu wr addr=0020 re-run after reset");
      cpuReq = 1'b0;
      step();

      // ---------------- randomized traffic vs model ----------------
      do_reset();
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      m_t = -1; m_streak = 0; m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (m_t < 0) begin
            if (cpuReq || dmaReq) begin
               gd = dmaReq && (!cpuReq || m_streak == STARVE);
               if (gd || !dmaReq) m_streak = 0;
               else if (m_streak < STARVE) m_streak++;
               m_owner = gd;
               m_we    = gd ? dmaWE : cpuWE;
               m_addr  = gd ? dmaAddr : cpuAddr;
               m_wd    = gd ? dmaWData : cpuWData;
               m_t     = 1;
            end
         end else if (m_t == WAIT + 2) begin
            m_t = -1;
         end else begin
            m_t++;
         end
         step();
         if (m_t == WAIT + 2) begin
            if (m_we) model_mem[m_addr[3:0]] = m_wd;
            else      exp_rd[m_owner] = model_mem[m_addr[3:0]];
            if (m_owner) dmaReq = 1'b0; else cpuReq = 1'b0;
            $display("[TB] rand %s %s addr=%h data=%h", m_owner ? "dma" : "cpu",
                     m_we ? "wr" : "rd", m_addr, m_we ? m_wd : exp_rd[m_owner]);
         end
         chk1("rand_busy", busy, m_t >= 1);
         chk1("rand_memWE", memWE, (m_t >= 1) && (m_t <= WAIT + 1) && m_we);
         chk1("rand_cpuAck", cpuAck, (m_t == WAIT + 2) && !m_owner);
         chk1("rand_dmaAck", dmaAck, (m_t == WAIT + 2) && m_owner);
         chk1("rand_owner", owner, m_owner);
         chk16("rand_cpuRData", cpuRData, exp_rd[0]);
         chk16("rand_dmaRData", dmaRData, exp_rd[1]);
         if ((m_t >= 1) && (m_t <= WAIT + 1)) begin
            chk16("rand_memAddr", memAddr, m_addr);
            if (m_we) chk16("rand_memWrite", memWrite, m_wd);
         end
         if (!cpuReq && $urandom_range(0, 2) == 0) begin
            cpuReq = 1'b1; cpuWE = 1'($urandom_range(0, 1));
            cpuAddr = 16'($urandom_range(0, 15)); cpuWData = 16'($urandom);
         end
         if (!dmaReq && $urandom_range(0, 2) == 0) begin
            dmaReq = 1'b1; dmaWE = 1'($urandom_range(0, 1));
            dmaAddr = 16'($urandom_range(0, 15)); dmaWData = 16'($urandom);
         end
      end
      cpuReq = 1'b0; dmaReq = 1'b0;

`ifdef MEM_ARB_LOCK_EN
      // ---------------- CPU lock ----------------
      do_reset();
      cpuLock = 1'b1;
      cpuReq = 1'b1; cpuWE = 1'b0; cpuAddr = 16'h0003;
      dmaReq = 1'b1; dmaWE = 1'b0; dmaAddr = 16'h0004;
      n_ack = 0;
      for (int c = 0; c < 60 && n_ack < 9; c++) begin
         step();
         if (cpuAck || dmaAck) begin
            chk1("lock_cpu_only", dmaAck, 1'b0);
            $display("[TB] lock xfer %0d -> %s", n_ack, dmaAck ? "dma" : "cpu");
            n_ack++;
         end
      end
      chk16("lock_xfer_count", 16'(n_ack), 16'd9);
      cpuLock = 1'b0;
      k = 0;
      for (int c = 0; c < 8 && k == 0; c++) begin
         step();
         if (cpuAck || dmaAck) begin
            chk1("unlock_dma_next", dmaAck, 1'b1);
            $display("[TB] unlock xfer -> %s", dmaAck ? "dma" : "cpu");
            k = 1;
         end
      end
      chk16("unlock_seen", 16'(k), 16'd1);
      cpuReq = 1'b0; dmaReq = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
